// File: rtl/dec_pkg.sv
// dec_pkg: shared widths, constants and decoder mode selector for dec3to8
package dec_pkg;
  localparam int SEL_W = 3;
  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] ZERO_OUT = '0;
  localparam logic [OUT_W-1:0] ONE_OUT = OUT_W'(1);
  typedef enum logic {MODE_SHIFT, MODE_CASE} mode_e;
endpackage

// File: rtl/dec3to8_core.sv
// dec3to8_core: combinational 3-to-8 one-hot decode, shift or case implementation
module dec3to8_core
  import dec_pkg::*;
#(
  parameter mode_e MODE = MODE_SHIFT
) (
  input  logic             en,
  input  logic [SEL_W-1:0] in,
  output logic [OUT_W-1:0] out
);
  logic en_ok;
  assign en_ok = (en === 1'b1);
  if (MODE == MODE_SHIFT) begin : g_shift
    // unknown select bits collapse to zero so X never reaches the outputs
    always_comb out = (en_ok && ((^in) !== 1'bx)) ? (ONE_OUT << in) : ZERO_OUT;
  end else begin : g_case
    logic [OUT_W-1:0] d;
    always_comb begin
      d = ZERO_OUT;
      case (in)
        3'd0: d = 8'h01;
        3'd1: d = 8'h02;
        3'd2: d = 8'h04;
        3'd3: d = 8'h08;
        3'd4: d = 8'h10;
        3'd5: d = 8'h20;
        3'd6: d = 8'h40;
        3'd7: d = 8'h80;
        default: d = ZERO_OUT;
      endcase
      out = d & {OUT_W{en_ok}};
    end
  end
endmodule

// File: rtl/dec3to8.sv
// dec3to8: dual-implementation one-hot decoder with output cross-check and sticky error
module dec3to8
  import dec_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] in,
  output logic [OUT_W-1:0] out_shift,
  output logic [OUT_W-1:0] out_case,
  output logic             mismatch,
  output logic             err_sticky
);
  logic [OUT_W-1:0] d_shift, d_case, q_shift, q_case;
  dec3to8_core #(.MODE(MODE_SHIFT)) u_shift (.en(en), .in(in), .out(d_shift));
  dec3to8_core #(.MODE(MODE_CASE))  u_case  (.en(en), .in(in), .out(d_case));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_shift <= ZERO_OUT;
      q_case  <= ZERO_OUT;
    end else begin
      q_shift <= d_shift;
      q_case  <= d_case;
    end
  // combinational variant still forces zeros while reset is held
  assign out_shift = OUT_REG ? q_shift : (rst_n ? d_shift : ZERO_OUT);
  assign out_case  = OUT_REG ? q_case  : (rst_n ? d_case  : ZERO_OUT);
  assign mismatch  = (out_shift != out_case);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_sticky <= 1'b0;
    else if (mismatch) err_sticky <= 1'b1;
endmodule

// File: tb/tb_dec3to8.sv
// tb_dec3to8: directed self-checking bench for dec3to8 with registered outputs
module tb_dec3to8;
  logic clk, rst_n, en;
  logic [2:0] in;
  logic [7:0] out_shift, out_case;
  logic mismatch, err_sticky;
  int checks = 0, errors = 0;

  dec3to8 #(.OUT_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in),
    .out_shift(out_shift), .out_case(out_case),
    .mismatch(mismatch), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] model(input logic e, input logic [2:0] s);
    logic [7:0] one;
    one = 8'h01;
    if (e !== 1'b1 || $isunknown(s)) return 8'h00;
    return one << s;
  endfunction

  task automatic step(input logic e, input logic [2:0] s);
    @(negedge clk);
    en = e;
    in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    step(1'b1, 3'd5);
    checks++;
    if (out_shift !== 8'h20) begin errors++; $display("FAIL pre_reset: out_shift=%h exp=20", out_shift); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_shift !== 8'h00 || out_case !== 8'h00 || mismatch !== 1'b0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: shift=%h case=%h mm=%b err=%b exp=00 00 0 0", out_shift, out_case, mismatch, err_sticky);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_shift !== 8'h00 || out_case !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: shift=%h case=%h exp=00", out_shift, out_case);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_shift !== 8'h20 || out_case !== 8'h20) begin
      errors++;
      $display("FAIL reset_release: shift=%h case=%h exp=20", out_shift, out_case);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i));
      exp = 8'h01 << i;
      checks++;
      if (out_shift !== exp || out_case !== exp || mismatch !== 1'b0) begin
        errors++;
        $display("FAIL sweep in=%0d: shift=%h case=%h mm=%b exp=%h", i, out_shift, out_case, mismatch, exp);
      end
    end
  endtask

  task automatic test_disable;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'(i));
      checks++;
      if (out_shift !== 8'h00 || out_case !== 8'h00 || mismatch !== 1'b0) begin
        errors++;
        $display("FAIL disable in=%0d: shift=%h case=%h exp=00", i, out_shift, out_case);
      end
    end
    step(1'b1, 3'd3);
    checks++;
    if (out_shift !== 8'h08 || out_case !== 8'h08) begin
      errors++;
      $display("FAIL enable_rise: shift=%h case=%h exp=08", out_shift, out_case);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      step(i[0], 3'd7);
      exp = i[0] ? 8'h80 : 8'h00;
      checks++;
      if (out_shift !== exp || out_case !== exp) begin
        errors++;
        $display("FAIL en_toggle cyc=%0d: shift=%h case=%h exp=%h", i, out_shift, out_case, exp);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] r;
    logic [7:0] exp;
    for (int i = 0; i < 200; i++) begin
      r = 4'($urandom);
      step(r[3], r[2:0]);
      exp = model(r[3], r[2:0]);
      checks++;
      if (out_shift !== exp || out_case !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d en=%b in=%0d: shift=%h case=%h exp=%h", i, r[3], r[2:0], out_shift, out_case, exp);
      end
    end
    checks++;
    if (err_sticky !== 1'b0) begin errors++; $display("FAIL random_sticky: err=%b exp=0", err_sticky); end
  endtask

  task automatic test_x_input;
    logic [2:0] xv;
    logic [7:0] exp;
    xv = 3'bx1x;
    step(1'b1, xv);
    exp = model(1'b1, in);
    checks++;
    if (out_shift !== exp || out_case !== exp || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL x_input: shift=%h case=%h mm=%b exp=%h", out_shift, out_case, mismatch, exp);
    end
  endtask

  task automatic test_fault;
    step(1'b1, 3'd3);
    #1;
    force dut.q_case = 8'h09;
    #1;
    checks++;
    if (mismatch !== 1'b1 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL fault_mismatch: mm=%b err=%b exp=1 0", mismatch, err_sticky);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_sticky !== 1'b1) begin errors++; $display("FAIL fault_sticky_set: err=%b exp=1", err_sticky); end
    release dut.q_case;
    step(1'b1, 3'd1);
    checks++;
    if (mismatch !== 1'b0 || err_sticky !== 1'b1 || out_case !== 8'h02) begin
      errors++;
      $display("FAIL fault_sticky_hold: mm=%b err=%b case=%h exp=0 1 02", mismatch, err_sticky, out_case);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (err_sticky !== 1'b0) begin errors++; $display("FAIL fault_sticky_clear: err=%b exp=0", err_sticky); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    en = 1'b0;
    in = 3'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    test_reset;
    test_sweep;
    test_disable;
    test_back_to_back;
    test_random;
    test_x_input;
    test_fault;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
